// File: rtl/ysyx_22050243_lsu_if.sv
// Bundle of the LSU request/response handshakes and the memory port.
// master = the core/driver side, slave = the LSU itself.
interface ysyx_22050243_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;

    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_misalign;

    logic        mem_r_en;
    logic        mem_w_en;
    logic [7:0]  mem_wmask;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    modport master (
        output req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_misalign,
        output resp_ready,
        input  mem_r_en, mem_w_en, mem_wmask, mem_addr, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_misalign,
        input  resp_ready,
        output mem_r_en, mem_w_en, mem_wmask, mem_addr, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/ysyx_22050243_lsu.sv
// Load/store unit: one request at a time, IDLE -> ACCESS -> RESP, lane-aligned 64-bit memory port.
// Define YSYX_22050243_LSU_MISALIGN_TRAP_EN to answer misaligned requests with resp_misalign instead of accessing memory.
module ysyx_22050243_lsu #(
    parameter int MEM_LAT = 1
) (
    input logic                      clk,
    input logic                      rst_n,
    ysyx_22050243_lsu_if.slave       io_bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic        r_wen;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;

    logic        r_mem_r_en;
    logic        r_mem_w_en;
    logic [7:0]  r_mem_wmask;
    logic [63:0] r_mem_addr;
    logic [63:0] r_mem_wdata;

    logic        r_resp_valid;
    logic [63:0] r_resp_rdata;
    logic        r_resp_misalign;

    logic        w_trap;
    logic [7:0]  w_size_mask;
    logic [7:0]  w_wmask;
    logic [63:0] w_wdata;
    logic [63:0] w_rshift;
    logic [63:0] w_load_data;

`ifdef YSYX_22050243_LSU_MISALIGN_TRAP_EN
    always_comb begin
        unique case (io_bus.req_size)
            2'b00:   w_trap = 1'b0;
            2'b01:   w_trap = io_bus.req_addr[0];
            2'b10:   w_trap = |io_bus.req_addr[1:0];
            default: w_trap = |io_bus.req_addr[2:0];
        endcase
    end
`else
    assign w_trap = 1'b0;
`endif

    always_comb begin
        unique case (r_size)
            2'b00:   w_size_mask = 8'h01;
            2'b01:   w_size_mask = 8'h03;
            2'b10:   w_size_mask = 8'h0F;
            default: w_size_mask = 8'hFF;
        endcase
    end

    // Lanes past byte 7 fall off the top: a misaligned access never spills into a second word.
    assign w_wmask  = w_size_mask << r_addr[2:0];
    assign w_wdata  = r_wdata << {r_addr[2:0], 3'b000};
    assign w_rshift = io_bus.mem_rdata >> {r_addr[2:0], 3'b000};

    always_comb begin
        unique case (r_size)
            2'b00:   w_load_data = r_unsigned ? {56'd0, w_rshift[7:0]}
                                              : {{56{w_rshift[7]}}, w_rshift[7:0]};
            2'b01:   w_load_data = r_unsigned ? {48'd0, w_rshift[15:0]}
                                              : {{48{w_rshift[15]}}, w_rshift[15:0]};
            2'b10:   w_load_data = r_unsigned ? {32'd0, w_rshift[31:0]}
                                              : {{32{w_rshift[31]}}, w_rshift[31:0]};
            default: w_load_data = w_rshift;
        endcase
    end

    // ACCESS opens with one address-setup cycle (both enables low), then the enable
    // phase; r_cnt counts the enable cycles still to go.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_cnt           <= 3'd0;
            r_wen           <= 1'b0;
            r_size          <= 2'b00;
            r_unsigned      <= 1'b0;
            r_addr          <= 64'd0;
            r_wdata         <= 64'd0;
            r_mem_r_en      <= 1'b0;
            r_mem_w_en      <= 1'b0;
            r_mem_wmask     <= 8'd0;
            r_mem_addr      <= 64'd0;
            r_mem_wdata     <= 64'd0;
            r_resp_valid    <= 1'b0;
            r_resp_rdata    <= 64'd0;
            r_resp_misalign <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (io_bus.req_valid) begin
                        r_wen      <= io_bus.req_wen;
                        r_size     <= io_bus.req_size;
                        r_unsigned <= io_bus.req_unsigned;
                        r_addr     <= io_bus.req_addr;
                        r_wdata    <= io_bus.req_wdata;
                        if (w_trap) begin
                            r_state         <= S_RESP;
                            r_resp_valid    <= 1'b1;
                            r_resp_misalign <= 1'b1;
                            r_resp_rdata    <= 64'd0;
                        end else begin
                            r_state    <= S_ACCESS;
                            r_mem_addr <= {io_bus.req_addr[63:3], 3'b000};
                            r_cnt      <= io_bus.req_wen ? 3'd1 : 3'(MEM_LAT);
                        end
                    end
                end
                S_ACCESS: begin
                    if (!r_mem_r_en && !r_mem_w_en) begin
                        if (r_wen) begin
                            r_mem_w_en  <= 1'b1;
                            r_mem_wmask <= w_wmask;
                            r_mem_wdata <= w_wdata;
                        end else begin
                            r_mem_r_en  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                        if (r_cnt == 3'd1) begin
                            r_mem_r_en   <= 1'b0;
                            r_mem_w_en   <= 1'b0;
                            r_mem_wmask  <= 8'd0;
                            r_mem_wdata  <= 64'd0;
                            r_mem_addr   <= 64'd0;
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= r_wen ? 64'd0 : w_load_data;
                        end
                    end
                end
                S_RESP: begin
                    if (io_bus.resp_ready) begin
                        r_state         <= S_IDLE;
                        r_resp_valid    <= 1'b0;
                        r_resp_rdata    <= 64'd0;
                        r_resp_misalign <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Gated by rst_n so req_ready is low during reset and high the moment it releases.
    assign io_bus.req_ready     = rst_n && (r_state == S_IDLE);
    assign io_bus.resp_valid    = r_resp_valid;
    assign io_bus.resp_rdata    = r_resp_rdata;
    assign io_bus.resp_misalign = r_resp_misalign;
    assign io_bus.mem_r_en      = r_mem_r_en;
    assign io_bus.mem_w_en      = r_mem_w_en;
    assign io_bus.mem_wmask     = r_mem_wmask;
    assign io_bus.mem_addr      = r_mem_addr;
    assign io_bus.mem_wdata     = r_mem_wdata;

endmodule

// File: tb/tb_ysyx_22050243_lsu.sv
// Scoreboard bench for ysyx_22050243_lsu: directed spec cases, random traffic, and reset abort.
module tb_ysyx_22050243_lsu;
    localparam int LAT = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ysyx_22050243_lsu_if bus();

    ysyx_22050243_lsu #(.MEM_LAT(LAT)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    logic [63:0] mem_word;
    assign bus.mem_rdata = bus.mem_r_en ? mem_word : 64'hA5A5_5A5A_DEAD_BEEF;

    typedef struct {
        logic        wen;
        logic [63:0] rdata;
        logic        mis;
        logic [63:0] addr;
        logic [7:0]  mask;
        logic [63:0] wdata;
        int          wcyc;
        int          rcyc;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   w_cyc   = 0;
    int   r_cyc   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic wen, input logic [1:0] size, input logic uns,
                                   input logic [63:0] addr, input logic [63:0] wdata,
                                   input logic [63:0] mword);
        exp_t        e;
        int          nb;
        int          off;
        logic        trap;
        logic [7:0]  m;
        logic [63:0] v;
        nb  = 1 << size;
        off = int'(addr[2:0]);
`ifdef YSYX_22050243_LSU_MISALIGN_TRAP_EN
        trap = (addr % 64'(nb)) != 64'd0;
`else
        trap = 1'b0;
`endif
        m = 8'd0;
        v = 64'd0;
        for (int i = 0; i < 8; i++) begin
            if (i < nb && off + i < 8) begin
                m[off + i]  = 1'b1;
                v[8*i +: 8] = mword[8*(off + i) +: 8];
            end
        end
        if (!uns && nb < 8 && v[8*nb - 1]) begin
            for (int j = 0; j < 8; j++)
                if (j >= nb) v[8*j +: 8] = 8'hFF;
        end
        e.wen   = wen;
        e.mis   = trap;
        e.addr  = addr & ~64'h7;
        e.mask  = m;
        e.wdata = wdata << (8 * off);
        e.rdata = (trap || wen) ? 64'd0 : v;
        e.wcyc  = (!trap && wen)  ? 1 : 0;
        e.rcyc  = (!trap && !wen) ? LAT : 0;
        e.lat   = trap ? 0 : (wen ? 2 : 1 + LAT);
        return e;
    endfunction

    // Memory-side checks each cycle against the request at the head of the queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_r_en || bus.mem_w_en) begin
                chk("rw_exclusive", 64'(bus.mem_r_en & bus.mem_w_en), 64'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_mem", 64'(bus.mem_r_en | bus.mem_w_en), 64'd0);
                end else if (bus.mem_w_en) begin
                    chk("w_addr",  bus.mem_addr,       exp_q[0].addr);
                    chk("w_mask",  64'(bus.mem_wmask), 64'(exp_q[0].mask));
                    chk("w_wdata", bus.mem_wdata,      exp_q[0].wdata);
                    w_cyc++;
                end else begin
                    chk("r_addr", bus.mem_addr,       exp_q[0].addr);
                    chk("r_mask", 64'(bus.mem_wmask), 64'd0);
                    r_cyc++;
                end
            end
            if (bus.resp_valid && bus.resp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", 64'(bus.resp_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("resp_rdata",    bus.resp_rdata,         e.rdata);
                    chk("resp_misalign", 64'(bus.resp_misalign), 64'(e.mis));
                    chk("w_en_cycles",   64'(w_cyc),             64'(e.wcyc));
                    chk("r_en_cycles",   64'(r_cyc),             64'(e.rcyc));
                    $display("[TB] txn wen=%0d addr=0x%h rdata=0x%h mis=%0d", e.wen, e.addr,
                             bus.resp_rdata, bus.resp_misalign);
                end
                w_cyc = 0;
                r_cyc = 0;
            end
        end
    end

    // Called just after a rising edge; returns just after the response-handshake edge.
    task automatic do_req(input logic wen, input logic [1:0] size, input logic uns,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [63:0] mword, input int hold);
        exp_t e;
        int   lat;
        e   = model(wen, size, uns, addr, wdata, mword);
        lat = 0;
        mem_word         = mword;
        bus.req_wen      = wen;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_valid    = 1'b1;
        exp_q.push_back(e);
        chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        while (!bus.resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(e.lat));
        for (int h = 0; h < hold; h++) begin
            chk("hold_valid",     64'(bus.resp_valid), 64'd1);
            chk("hold_rdata",     bus.resp_rdata,      e.rdata);
            chk("hold_req_ready", 64'(bus.req_ready),  64'd0);
            @(posedge clk); #1;
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        chk("post_valid",     64'(bus.resp_valid), 64'd0);
        chk("post_req_ready", 64'(bus.req_ready),  64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_wen      = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 64'd0;
        bus.req_wdata    = 64'd0;
        bus.resp_ready   = 1'b0;
        mem_word         = 64'd0;

        #12;
        chk("rst_req_ready",  64'(bus.req_ready),  64'd0);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_mem_w_en",   64'(bus.mem_w_en),   64'd0);
        chk("rst_mem_r_en",   64'(bus.mem_r_en),   64'd0);
        chk("rst_mem_addr",   bus.mem_addr,        64'd0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        #1;
        chk("rel_req_ready", 64'(bus.req_ready), 64'd1);
        @(posedge clk); #1;

        do_req(1'b1, 2'b11, 1'b0, 64'h8000_0008, 64'h1122_3344_5566_7788, 64'd0, 0);
        do_req(1'b1, 2'b00, 1'b0, 64'h8000_0003, 64'h0000_0000_0000_00AB, 64'd0, 1);
        do_req(1'b0, 2'b01, 1'b0, 64'h8000_0006, 64'd0, 64'h8001_0000_0000_0000, 0);
        do_req(1'b0, 2'b01, 1'b1, 64'h8000_0006, 64'd0, 64'h8001_0000_0000_0000, 5);
        do_req(1'b0, 2'b10, 1'b0, 64'h8000_0002, 64'd0, 64'h1234_5678_9ABC_DEF0, 0);
        do_req(1'b0, 2'b00, 1'b0, 64'h8000_0007, 64'd0, 64'hF123_4567_89AB_CDEF, 0);
        do_req(1'b0, 2'b11, 1'b1, 64'h8000_0010, 64'd0, 64'hFEDC_BA98_7654_3210, 0);
        do_req(1'b1, 2'b10, 1'b0, 64'h8000_0006, 64'hCAFE_F00D_1234_5678, 64'd0, 0);

        for (int k = 0; k < 24; k++) begin
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   64'h8000_0000 + 64'($urandom_range(0, 255)),
                   {32'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)},
                   $urandom_range(0, 2));
        end

        // Abort a store while its write enable is up.
        bus.req_wen   = 1'b1;
        bus.req_size  = 2'b11;
        bus.req_addr  = 64'h8000_0010;
        bus.req_wdata = 64'h0123_4567_89AB_CDEF;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort_w_en_up", 64'(bus.mem_w_en), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_w_en_drop", 64'(bus.mem_w_en),   64'd0);
        chk("abort_mem_addr",  bus.mem_addr,        64'd0);
        chk("abort_resp",      64'(bus.resp_valid), 64'd0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("abort_no_resp", 64'(bus.resp_valid), 64'd0);
            chk("abort_idle",    64'(bus.req_ready),  64'd1);
        end

        do_req(1'b0, 2'b10, 1'b1, 64'h8000_0004, 64'd0, 64'h89AB_CDEF_0000_0000, 0);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ysyx_22050243_lsu.md
YSYX_22050243_LSU -- requirements
Module: ysyx_22050243_LSU

Interface
REQ-001 SHALL have parameter: MEM_LAT, 1, number of cycles mem_r_en is held before mem_rdata is sampled (legal 1..4).
REQ-002 SHALL have port: clk  input  1  clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: req_valid in 1 access request; req_ready out 1 request accepted.
REQ-005 SHALL have ports: req_wen in 1 (1=store, 0=load); req_size in 2 (00 B, 01 H, 10 W, 11 D); req_unsigned in 1 zero-extend load.
REQ-006 SHALL have ports: req_addr in 64 byte address; req_wdata in 64 store data, right-justified.
REQ-007 SHALL have ports: resp_valid out 1; resp_ready in 1; resp_rdata out 64 extended load data; resp_misalign out 1 misaligned flag.
REQ-008 SHALL have memory ports: mem_r_en out 1; mem_w_en out 1; mem_wmask out 8; mem_addr out 64; mem_wdata out 64; mem_rdata in 64 (combinational read data).

Function
REQ-009 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-010 SHALL assert req_ready only in IDLE; handshake req_valid&&req_ready latches all req_* fields and moves to ACCESS (or RESP per REQ-017).
REQ-011 SHALL drive mem_addr = latched addr with bits [2:0] cleared, only while in ACCESS; 0 otherwise.
REQ-012 Store: SHALL assert mem_w_en for exactly one ACCESS cycle; mem_wmask = size mask (0x01/0x03/0x0F/0xFF) shifted left by addr[2:0], truncated to 8 bits; mem_wdata = req_wdata shifted left by 8*addr[2:0]; then RESP.
REQ-013 Load: SHALL assert mem_r_en for MEM_LAT consecutive ACCESS cycles (down-counter), mem_wmask=0, sample mem_rdata at the final ACCESS edge, then RESP.
REQ-014 Load data SHALL be mem_rdata shifted right by 8*addr[2:0], cut to size, sign-extended unless req_unsigned (D ignores req_unsigned).
REQ-015 In RESP, resp_valid SHALL be 1 and resp_rdata/resp_misalign stable until resp_valid&&resp_ready, then IDLE; store response resp_rdata=0.
REQ-016 Latency: request accepted at edge N -> resp_valid high after edge N+1+MEM_LAT for loads, N+2 for stores; back-to-back request accepted in the cycle after response handshake.
REQ-017 Misaligned = addr not a multiple of (1<<size); handling per Configuration.
REQ-018 mem_r_en and mem_w_en SHALL never both be 1; neither SHALL be 1 outside ACCESS.

Reset
REQ-019 rst_n low SHALL immediately force IDLE, counter 0, all latched fields 0, and all outputs 0 except req_ready=1 after release.
REQ-020 Reset during ACCESS SHALL deassert mem_w_en/mem_r_en asynchronously; no response is produced for the aborted request.

Configuration
REQ-021 Macro YSYX_22050243_LSU_MISALIGN_TRAP_EN defined: misaligned request SHALL skip ACCESS (no memory enable), go to RESP with resp_misalign=1, resp_rdata=0.
REQ-022 Macro undefined: resp_misalign SHALL be tied 0; misaligned access performed normally with mask bits beyond lane 7 dropped (no second access).

Verification
REQ-023 Store D, addr 0x80000008, wdata 0x1122334455667788 -> one cycle mem_w_en, mem_addr 0x80000008, wmask 0xFF, resp_valid at N+2, rdata 0.
REQ-024 Store B, addr 0x80000003, wdata 0xAB -> wmask 0x08, mem_wdata 0xAB000000, mem_addr 0x80000000.
REQ-025 Load H signed, addr 0x80000006, mem_rdata 0x8001_0000_0000_0000, MEM_LAT=2 -> mem_r_en 2 cycles, resp_rdata 0xFFFFFFFFFFFF8001; unsigned -> 0x8001.
REQ-026 resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata stable, req_ready 0 throughout; new req accepted cycle after handshake.
REQ-027 Load W addr 0x80000002 -> with TRAP_EN: no mem_r_en, resp_misalign=1, rdata 0; without: mem_r_en asserted, resp_misalign=0.
REQ-028 rst_n pulsed low mid-ACCESS of a store -> mem_w_en drops same cycle, FSM IDLE, no resp_valid.
